// File: rtl/mem_pkg.sv
// Shared definitions for the data- and instruction-side memory responders:
// FSM encoding, word offset and error-cause codes.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_OFFSET = 2;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_cause_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with write enable and no reset.
// The read register only updates on enabled reads, so it holds the last load.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AIW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           en,
  input  logic           we,
  input  logic [AIW-1:0] addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: one request at a time, fixed programmable
// latency, one-cycle response strobe, busy while a transaction is in flight.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          req_ready,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          busy
);

  localparam int AIW = $clog2(DEPTH);
  localparam int CW  = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  state_e        state;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [31:0]   lat_wdata;
  logic          rdata_sel;
  logic [31:0]   ram_rdata;

  logic          accept;
  logic          enter_resp;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic          cur_err;
  err_cause_e    cause;

  assign req_ready = (state == IDLE) & ~rst;
  assign busy      = (state != IDLE);
  assign accept    = req_valid & req_ready;

  // With LATENCY==1 the RAM access happens on the accept edge, so the live
  // request fields are used in IDLE and the latched copies otherwise.
  assign cur_we    = (state == IDLE) ? req_we    : lat_we;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;

  always_comb begin
    cause = ERR_NONE;
    if (cur_addr[WORD_OFFSET-1:0] != '0) begin
      cause = ERR_MISALIGN;
    end else if (cur_addr[AW-1:WORD_OFFSET] >= (AW-WORD_OFFSET)'(DEPTH)) begin
      cause = ERR_RANGE;
    end
  end

  assign cur_err = (cause != ERR_NONE);

  assign enter_resp = ~rst & (((state == IDLE) & accept & (LATENCY == 1)) |
                              ((state == WAIT) & (cnt == '0)));

  dmem_array #(
    .DEPTH (DEPTH),
    .AIW   (AIW)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp & ~cur_err),
    .we    (cur_we),
    .addr  (cur_addr[AIW+WORD_OFFSET-1:WORD_OFFSET]),
    .wdata (cur_wdata),
    .rdata (ram_rdata)
  );

  // Stores and errors report zero data without disturbing the RAM read register.
  assign resp_rdata = rdata_sel ? ram_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_sel  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= cur_err;
              rdata_sel  <= ~cur_we & ~cur_err;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= cur_err;
            rdata_sel  <= ~cur_we & ~cur_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=3 instance driven by
// directed and random transactions, plus a LATENCY=1 instance for streaming.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int AW    = 32;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;

  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_b, req_we_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
  logic [31:0] resp_rdata_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] model   [DEPTH];
  logic [31:0] model_b [8];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1), .AW(AW)) dut_lat1 (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid_b),
    .req_we     (req_we_b),
    .req_addr   (req_addr_b),
    .req_wdata  (req_wdata_b),
    .req_ready  (req_ready_b),
    .resp_valid (resp_valid_b),
    .resp_rdata (resp_rdata_b),
    .resp_err   (resp_err_b),
    .busy       (busy_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic bit addrErr(input logic [31:0] addr);
    return (addr % 4 != 0) || ((addr / 4) >= DEPTH);
  endfunction

  // Called just after a rising edge with the responder idle; returns just
  // after the edge that brings it back to idle. With overlap set, the next
  // request is presented while the current one is still in flight.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit overlap,
                               input logic nwe, input logic [31:0] naddr,
                               input logic [31:0] nwdata);
    int          waited;
    logic        exp_err;
    logic [31:0] exp_data;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("accept_wait", waited, 0);
    exp_err  = addrErr(addr);
    exp_data = (!we && !exp_err) ? model[addr / 4] : 32'h0;
    if (we && !exp_err) model[addr / 4] = wdata;
    @(posedge clk); #1;
    if (overlap) begin
      req_we    = nwe;
      req_addr  = naddr;
      req_wdata = nwdata;
    end else begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      checkOutput("resp_valid", resp_valid, k == LAT);
      checkOutput("busy", busy, k <= LAT);
      checkOutput("req_ready", req_ready, k > LAT);
      if (k == LAT) begin
        checkOutput("resp_rdata", resp_rdata, exp_data);
        checkOutput("resp_err", resp_err, exp_err);
      end
      if (k <= LAT) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic        ops_we   [16];
    logic [31:0] ops_addr [16];
    logic [31:0] ops_data [16];
    logic        pend, exp_err_b;
    logic [31:0] exp_data_b;
    int          due, last_acc, op_idx, cyc, r;
    logic [31:0] a;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;

    // Reset held for two cycles, outputs quiet throughout.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_rdata", resp_rdata, 0);
      checkOutput("rst_resp_err", resp_err, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_req_ready", req_ready, 0);
    end
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", req_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    // Prefill the low words so later loads have known contents.
    for (int w = 0; w < 32; w++)
      applyStimulus(1'b1, 32'(w * 4), $urandom, 1'b0, 1'b0, '0, '0);

    $display("[TB] store then load");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, '0, '0);

    $display("[TB] misaligned and out-of-range");
    applyStimulus(1'b1, 32'h13, 32'hCAFEF00D, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 32'h400, 32'h0, 1'b0, 1'b0, '0, '0);

    $display("[TB] request while busy");
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA5A5_5A5A);
    applyStimulus(1'b1, 32'h20, 32'hA5A5_5A5A, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("no_dup_resp", resp_valid, 0);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b0, 1'b0, '0, '0);

    $display("[TB] reset mid-transaction");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h12345678;
    checkOutput("abort_ready", req_ready, 1);
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 1);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_resp_valid", resp_valid, 0);
    checkOutput("abort_busy_rst", busy, 0);
    checkOutput("abort_ready_rst", req_ready, 0);
    checkOutput("abort_rdata_rst", resp_rdata, 0);
    checkOutput("abort_err_rst", resp_err, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("abort_no_resp", resp_valid, 0);
    end
    applyStimulus(1'b0, 32'h40, 32'h0, 1'b0, 1'b0, '0, '0);

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, 31)) * 4;
      else if (r == 7) a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else             a = 32'($urandom_range(DEPTH, 1 << 20)) * 4;
      applyStimulus(1'($urandom), a, $urandom, 1'b0, 1'b0, '0, '0);
    end

    $display("[TB] LATENCY=1 streaming");
    for (int i = 0; i < 16; i++) begin
      ops_we[i]   = (i < 8);
      ops_addr[i] = 32'((i % 8) * 4);
      ops_data[i] = $urandom;
    end
    pend = 1'b0; due = 0; last_acc = 0; op_idx = 0; cyc = 0;
    exp_err_b = 1'b0; exp_data_b = '0;
    while ((op_idx < 16 || pend) && cyc < 80) begin
      req_valid_b = (op_idx < 16);
      if (op_idx < 16) begin
        req_we_b    = ops_we[op_idx];
        req_addr_b  = ops_addr[op_idx];
        req_wdata_b = ops_data[op_idx];
      end
      checkOutput("lat1_resp_valid", resp_valid_b, pend && due == cyc);
      if (pend && due == cyc) begin
        checkOutput("lat1_rdata", resp_rdata_b, exp_data_b);
        checkOutput("lat1_err", resp_err_b, exp_err_b);
        pend = 1'b0;
      end
      if (req_ready_b && op_idx < 16) begin
        if (op_idx > 0) checkOutput("lat1_period", cyc - last_acc, 2);
        last_acc   = cyc;
        exp_err_b  = 1'b0;
        exp_data_b = ops_we[op_idx] ? 32'h0 : model_b[ops_addr[op_idx] / 4];
        if (ops_we[op_idx]) model_b[ops_addr[op_idx] / 4] = ops_data[op_idx];
        pend = 1'b1;
        due  = cyc + 1;
        op_idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("lat1_all_done", op_idx + (pend ? 100 : 0), 16);
    req_valid_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
